// File: rtl/sync_pkg.sv
// Shared types and default widths for the barrier scheduler.
package sync_pkg;

  localparam int NUM_CPU_DEF = 4;
  localparam int TMO_W_DEF   = 16;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GATHER  = 3'd1,
    ST_RELEASE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_ERROR   = 3'd4
  } state_e;

endpackage

// File: rtl/barrier_timer.sv
// Saturating straggler timer; hits one cycle before reaching the threshold.
module barrier_timer
  import sync_pkg::*;
#(
  parameter int W = TMO_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] thr,
  output logic         hit
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        count <= '0;
    else if (clr)                      count <= '0;
    else if (inc && (count != '1))     count <= count + 1'b1;
  end

  // A zero threshold disables the timeout entirely.
  assign hit = (thr != '0) && (count == (thr - 1'b1));

endmodule

// File: rtl/sync_barrier_ctrl.sv
// Barrier scheduler: gathers per-core syncs, releases masked cores with a
// one-cycle continue pulse, and flags stragglers on timeout.
module sync_barrier_ctrl
  import sync_pkg::*;
#(
  parameter int NUM_CPU = NUM_CPU_DEF,
  parameter int TMO_W   = TMO_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               cfg_load,
  input  logic [NUM_CPU-1:0] cfg_mask,
  input  logic [TMO_W-1:0]   cfg_timeout,
  input  logic               clear_err,
  input  logic [NUM_CPU-1:0] cpu_sync,
  input  logic [NUM_CPU-1:0] cpu_halt,
  output logic [NUM_CPU-1:0] cpu_continue,
  output logic [CNT_W-1:0]   barrier_count,
  output logic [NUM_CPU-1:0] err_mask,
  output logic               timeout_err,
  output logic               all_halted,
  output logic               busy
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_GATHER  = ST_GATHER;
  localparam logic [2:0] S_RELEASE = ST_RELEASE;
  localparam logic [2:0] S_DRAIN   = ST_DRAIN;
  localparam logic [2:0] S_ERROR   = ST_ERROR;

  logic [2:0]         state_q, state_d;
  logic [NUM_CPU-1:0] mask_q, mask_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [NUM_CPU-1:0] arrived_q, arrived_d;
  logic [NUM_CPU-1:0] cont_d, err_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [NUM_CPU-1:0] eff_arr;
  logic               complete, tmr_clr, tmr_inc, tmr_hit, abort;

  // Halted cores count as arrived so a parked core never blocks the barrier.
  assign eff_arr  = (arrived_q | cpu_sync | cpu_halt) & mask_q;
  assign complete = (mask_q != '0) && (eff_arr == mask_q);
  assign abort    = !enable && ((state_q == S_GATHER) || (state_q == S_RELEASE) ||
                                (state_q == S_DRAIN));

  barrier_timer #(.W(TMO_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .thr   (tmo_q),
    .hit   (tmr_hit)
  );

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    tmo_d     = tmo_q;
    arrived_d = arrived_q;
    cont_d    = '0;
    cnt_d     = barrier_count;
    err_d     = err_mask;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    if (abort) begin
      state_d   = S_IDLE;
      arrived_d = '0;
      tmr_clr   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tmr_clr = 1'b1;
          if (cfg_load) begin
            mask_d = cfg_mask;
            tmo_d  = cfg_timeout;
          end
          if (enable) begin
            state_d   = S_GATHER;
            arrived_d = '0;
          end
        end
        S_GATHER: begin
          arrived_d = arrived_q | (cpu_sync & mask_q);
          tmr_inc   = (arrived_q != '0);
          // Completion takes priority over a timeout on the same edge.
          if (complete) begin
            state_d = S_RELEASE;
          end else if (tmr_hit) begin
            state_d = S_ERROR;
            err_d   = mask_q & ~eff_arr;
          end
        end
        S_RELEASE: begin
          cont_d    = mask_q & ~cpu_halt;
          cnt_d     = barrier_count + 1'b1;
          arrived_d = '0;
          tmr_clr   = 1'b1;
          state_d   = S_DRAIN;
        end
        S_DRAIN: begin
          // Hold until released syncs drop so one level is not counted twice.
          if ((cpu_sync & mask_q) == '0) state_d = S_GATHER;
        end
        S_ERROR: begin
          tmr_clr = 1'b1;
          if (clear_err) begin
            state_d = S_IDLE;
            err_d   = '0;
          end
        end
        default: begin
          state_d   = S_IDLE;
          arrived_d = '0;
          tmr_clr   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      tmo_q         <= '0;
      arrived_q     <= '0;
      cpu_continue  <= '0;
      barrier_count <= '0;
      err_mask      <= '0;
      timeout_err   <= 1'b0;
      all_halted    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      tmo_q         <= tmo_d;
      arrived_q     <= arrived_d;
      cpu_continue  <= cont_d;
      barrier_count <= cnt_d;
      err_mask      <= err_d;
      timeout_err   <= (state_d == S_ERROR);
      all_halted    <= (mask_q != '0) && ((cpu_halt & mask_q) == mask_q);
      busy          <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_sync_barrier_ctrl.sv
// Directed bench for sync_barrier_ctrl; continue pulses are scoreboarded.
`timescale 1ns/1ps
module tb_sync_barrier_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, cfg_load, clear_err;
  logic [3:0]  cfg_mask, cpu_sync, cpu_halt;
  logic [15:0] cfg_timeout;
  logic [3:0]  cpu_continue, err_mask;
  logic [15:0] barrier_count;
  logic        timeout_err, all_halted, busy;

  typedef struct {
    logic [3:0]  cont;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  sync_barrier_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .cfg_load      (cfg_load),
    .cfg_mask      (cfg_mask),
    .cfg_timeout   (cfg_timeout),
    .clear_err     (clear_err),
    .cpu_sync      (cpu_sync),
    .cpu_halt      (cpu_halt),
    .cpu_continue  (cpu_continue),
    .barrier_count (barrier_count),
    .err_mask      (err_mask),
    .timeout_err   (timeout_err),
    .all_halted    (all_halted),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse expected two edges after the cycle in which the completing sync is driven.
  task automatic expect_pulse(input logic [3:0] cont, input logic [15:0] cnt);
    exp_t e;
    e.cont = cont;
    e.cnt  = cnt;
    e.cyc  = cyc + 2;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset && (cpu_continue != 4'h0)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {28'h0, cpu_continue}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_mask", {28'h0, cpu_continue}, {28'h0, e.cont});
        chk("pulse_count", {16'h0, barrier_count}, {16'h0, e.cnt});
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; cfg_load = 1'b0; clear_err = 1'b0;
    cfg_mask = 4'h0; cfg_timeout = 16'd0; cpu_sync = 4'h0; cpu_halt = 4'h0;
    tick(2);
    chk("rst_cont", {28'h0, cpu_continue}, 32'h0);
    chk("rst_count", {16'h0, barrier_count}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_terr", {31'h0, timeout_err}, 32'h0);
    reset = 1'b1;
    tick(1);

    // Basic release, staggered arrivals, held syncs, resync
    cfg_load = 1'b1; cfg_mask = 4'hF; cfg_timeout = 16'd0; enable = 1'b1;
    tick(1);
    cfg_load = 1'b0;
    chk("busy_gather", {31'h0, busy}, 32'h1);
    cpu_sync = 4'b0001; tick(1);
    cpu_sync = 4'b0101; tick(1);
    cpu_sync = 4'b0111; tick(1);
    cpu_sync = 4'b1111; expect_pulse(4'hF, 16'd1);
    tick(6);
    chk("held_count", {16'h0, barrier_count}, 32'd1);
    cpu_sync = 4'h0; tick(2);
    cpu_sync = 4'hF; expect_pulse(4'hF, 16'd2);
    tick(3);
    cpu_sync = 4'h0; tick(2);
    chk("resync_count", {16'h0, barrier_count}, 32'd2);

    // Halted participant
    cpu_halt = 4'b1000;
    cpu_sync = 4'b0111; expect_pulse(4'b0111, 16'd3);
    tick(3);
    chk("halt_all0", {31'h0, all_halted}, 32'h0);
    cpu_sync = 4'h0; enable = 1'b0; tick(1);
    cpu_halt = 4'hF; tick(1);
    chk("halt_all1", {31'h0, all_halted}, 32'h1);
    cpu_halt = 4'h0; tick(1);

    // Timeout with cores 2,3 missing
    cfg_load = 1'b1; cfg_timeout = 16'd10; enable = 1'b1;
    tick(1);
    cfg_load = 1'b0;
    cpu_sync = 4'b0011;
    tick(10);
    chk("tmo_early", {31'h0, timeout_err}, 32'h0);
    tick(1);
    chk("tmo_err", {31'h0, timeout_err}, 32'h1);
    chk("tmo_mask", {28'h0, err_mask}, 32'hC);
    cpu_sync = 4'h0; enable = 1'b0; tick(1);
    chk("tmo_hold", {31'h0, timeout_err}, 32'h1);
    clear_err = 1'b1; tick(1);
    clear_err = 1'b0;
    chk("clr_terr", {31'h0, timeout_err}, 32'h0);
    chk("clr_mask", {28'h0, err_mask}, 32'h0);
    chk("clr_busy", {31'h0, busy}, 32'h0);

    // Completion sampled on the same edge the timeout would fire
    enable = 1'b1; tick(1);
    cpu_sync = 4'b0011;
    tick(10);
    cpu_sync = 4'hF; expect_pulse(4'hF, 16'd4);
    tick(3);
    chk("race_noerr", {31'h0, timeout_err}, 32'h0);
    cpu_sync = 4'h0; tick(2);

    // Abort in GATHER clears partial arrivals but keeps the count
    cpu_sync = 4'b0011; tick(1);
    cpu_sync = 4'h0; enable = 1'b0; tick(1);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_count", {16'h0, barrier_count}, 32'd4);
    enable = 1'b1; tick(1);
    cpu_sync = 4'b1100; tick(3);
    chk("abort_noarr", {16'h0, barrier_count}, 32'd4);
    cpu_sync = 4'h0; enable = 1'b0; tick(1);

    // Asynchronous reset mid-cycle
    enable = 1'b1; tick(1);
    chk("pre_rst_busy", {31'h0, busy}, 32'h1);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_count", {16'h0, barrier_count}, 32'h0);
    chk("arst_cont", {28'h0, cpu_continue}, 32'h0);
    enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    tick(1);

    // Config gating: load outside IDLE is ignored
    cfg_load = 1'b1; cfg_mask = 4'hF; cfg_timeout = 16'd0; enable = 1'b1;
    tick(1);
    cfg_load = 1'b1; cfg_mask = 4'h3; tick(1);
    cfg_load = 1'b0;
    cpu_sync = 4'b0011; tick(4);
    chk("gate_ignored", {16'h0, barrier_count}, 32'h0);
    cpu_sync = 4'h0; enable = 1'b0; tick(1);
    cfg_load = 1'b1; cfg_mask = 4'h3; enable = 1'b1; tick(1);
    cfg_load = 1'b0;
    cpu_sync = 4'b0011; expect_pulse(4'b0011, 16'd1);
    tick(3);
    cpu_sync = 4'h0; enable = 1'b0; tick(1);

    // Empty mask never releases
    cfg_load = 1'b1; cfg_mask = 4'h0; enable = 1'b1; tick(1);
    cfg_load = 1'b0;
    cpu_sync = 4'hF; tick(100);
    chk("mask0_count", {16'h0, barrier_count}, 32'd1);
    chk("mask0_busy", {31'h0, busy}, 32'h1);
    chk("mask0_allh", {31'h0, all_halted}, 32'h0);
    cpu_sync = 4'h0; enable = 1'b0; tick(2);

    chk("pending_pulses", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_barrier_ctrl.md
Name: sync_barrier_ctrl

Overview:
Barrier scheduler for the four-core system. It gathers per-CPU sync requests, releases participating cores together with a one-cycle continue pulse, and detects stragglers with a programmable timeout. It sits between the CPU sync/halt/continue wires and the NIOS-facing control block, which enables it and reads its counters and error status.

Parameters:
NUM_CPU, 4, number of cores served (one bit each in every mask/vector)
TMO_W, 16, width of the timeout threshold and the timeout timer
CNT_W, 16, width of the completed-barrier counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  run gate from the control block; low forces IDLE
cfg_load  in  1  load cfg_mask/cfg_timeout; honoured only in IDLE
cfg_mask  in  NUM_CPU  participating-core mask
cfg_timeout  in  TMO_W  straggler timeout in cycles; 0 = disabled
clear_err  in  1  leave ERROR, clear err_mask
cpu_sync  in  NUM_CPU  per-core "arrived at barrier" level
cpu_halt  in  NUM_CPU  per-core halted level
cpu_continue  out  NUM_CPU  release pulse per core
barrier_count  out  CNT_W  completed barriers, wraps
err_mask  out  NUM_CPU  cores missing at timeout
timeout_err  out  1  high while in ERROR
all_halted  out  1  every masked core halted
busy  out  1  state != IDLE

Behaviour:
- All outputs are registered. On reset low: state IDLE; mask_q=0; tmo_q=0; arrived_q=0; timer=0; cpu_continue=0; barrier_count=0; err_mask=0; timeout_err=0; all_halted=0; busy=0.
- eff_arr = (arrived_q | cpu_sync | cpu_halt) & mask_q.
- complete = (mask_q != 0) && (eff_arr == mask_q).
- States: IDLE, GATHER, RELEASE, DRAIN, ERROR.
- IDLE: if cfg_load, latch mask_q and tmo_q. If enable, go to GATHER with arrived_q=0 and timer=0. If cfg_load and enable arrive in the same cycle, the new config is used.
- GATHER: arrived_q |= cpu_sync & mask_q.
  - Timer increments each cycle while arrived_q != 0. Saturates, never wraps.
  - If complete, go to RELEASE.
  - Else if tmo_q != 0 and timer == tmo_q - 1, go to ERROR with err_mask = mask_q & ~eff_arr.
  - complete wins over a simultaneous timeout.
  - mask_q == 0: stay in GATHER indefinitely, never release.
- RELEASE, exactly one cycle: cpu_continue = mask_q & ~cpu_halt; barrier_count += 1 (wraps); arrived_q=0; timer=0. Next state DRAIN.
- Latency: complete sampled at edge N; the pulse is high between edges N+1 and N+2.
- DRAIN: cpu_continue=0. Wait until (cpu_sync & mask_q) == 0, then go to GATHER. This prevents one held sync level from being counted twice.
- ERROR: timeout_err=1 and err_mask holds its value. On clear_err, go to IDLE and clear err_mask. enable does not exit ERROR.
- enable low in GATHER, RELEASE or DRAIN: next state IDLE; arrived_q, timer and cpu_continue are cleared; barrier_count is kept.
- A halted core counts as arrived and receives no continue. all_halted = (mask_q != 0) && ((cpu_halt & mask_q) == mask_q), registered every cycle.
- cfg_load outside IDLE is ignored.

Decomposition:
- Shared package sync_pkg holds:
  - the state enum (logic [2:0]: IDLE, GATHER, RELEASE, DRAIN, ERROR);
  - NUM_CPU_DEF = 4;
  - the default widths.
- One sub-module, barrier_timer: a saturating up-counter with clear, enable and `hit` compare against the threshold, where threshold 0 never hits. Everything else lives in the top module.

Test Plan:
- Basic release: mask=4'hF, timeout=0, enable. Sync cores 0, 2, 1 and 3 on successive cycles, held high → cpu_continue=4'hF for exactly one cycle, starting one cycle after core 3's sync; barrier_count=1. Hold syncs 5 cycles → no second pulse. Drop syncs, resync → count=2.
- Halted participant: mask=4'hF, cpu_halt=4'b1000. Sync cores 0–2 → cpu_continue=4'b0111 and all_halted=0. Set cpu_halt=4'hF → all_halted=1 on the next cycle.
- Timeout: mask=4'hF, timeout=10. Cores 0 and 1 sync at cycle 0 → ERROR on the 10th cycle after the first arrival, with err_mask=4'b1100 and timeout_err=1. clear_err → IDLE, err_mask=0, busy=0.
- Simultaneous completion and timeout: timeout=10, last sync on exactly cycle 9 → RELEASE, no error.
- Reset and abort mid-operation: in GATHER with arrived_q=4'b0011, drop enable → IDLE, arrived_q=0, count kept. Then assert reset low asynchronously, mid-cycle → all outputs zero immediately.
- Config gating: cfg_load with mask=4'h3 while in GATHER → ignored; same load in IDLE → only cores 0–1 are required and only bits 0–1 pulse. mask=0 with syncs → no pulse after 100 cycles.
